// File: rtl/pool2d_stream.sv
// Streaming multi-channel 2-D max/average pooling over raster-order pixels.
// Keeps one row of per-window partial results per lane.
module pool2d_stream #(
    parameter int DATA_W       = 8,
    parameter int CHANNELS     = 4,
    parameter int IMAGE_HEIGHT = 24,
    parameter int IMAGE_WIDTH  = 24,
    parameter int POOL_H       = 2,
    parameter int POOL_W       = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         pool_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         out_last
);

    localparam int OUT_H = IMAGE_HEIGHT / POOL_H;
    localparam int OUT_W = IMAGE_WIDTH / POOL_W;
    localparam int NWIN  = POOL_H * POOL_W;
    localparam int SH    = $clog2(NWIN);
    localparam int ACC_W = DATA_W + SH;
    localparam int CW    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int PCW   = (POOL_W > 1) ? $clog2(POOL_W) : 1;
    localparam int PRW   = (POOL_H > 1) ? $clog2(POOL_H) : 1;
    localparam int WCW   = $clog2(OUT_W + 1);
    localparam int WRW   = $clog2(OUT_H + 1);
    localparam int WI    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [PCW-1:0]          pc_q, pc_d;
    logic [PRW-1:0]          pr_q, pr_d;
    logic [WCW-1:0]          wc_q, wc_d;
    logic [WRW-1:0]          wr_q, wr_d;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic [CHANNELS*DATA_W-1:0] out_data_q;

    logic signed [ACC_W-1:0] acc_q [OUT_W][CHANNELS];
    logic signed [ACC_W-1:0] px [CHANNELS];
    logic signed [ACC_W-1:0] en [CHANNELS];
    logic signed [ACC_W-1:0] merged [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] res;

    logic           accept, first, in_win, done;
    logic           last_col, last_row, win_last, cur_mode;
    logic           pc_end, pr_end;
    logic [WI-1:0]  wi;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_comb begin
        accept   = in_valid && in_ready;
        last_col = col_q == CW'(IMAGE_WIDTH - 1);
        last_row = row_q == RW'(IMAGE_HEIGHT - 1);
        pc_end   = pc_q == PCW'(POOL_W - 1);
        pr_end   = pr_q == PRW'(POOL_H - 1);
        in_win   = (wc_q < WCW'(OUT_W)) && (wr_q < WRW'(OUT_H));
        first    = (pc_q == '0) && (pr_q == '0);
        done     = accept && in_win && pc_end && pr_end;
        win_last = (wc_q == WCW'(OUT_W - 1)) && (wr_q == WRW'(OUT_H - 1));
        // The first pixel of a frame uses the live mode, later ones the latched copy.
        cur_mode = (state_q == IDLE) ? pool_mode : mode_q;
        wi       = WI'(wc_q);
        res      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            px[c] = ACC_W'(signed'(in_data[c*DATA_W +: DATA_W]));
            en[c] = acc_q[wi][c];
            if (first)
                merged[c] = px[c];
            else if (cur_mode)
                merged[c] = en[c] + px[c];
            else
                merged[c] = (px[c] > en[c]) ? px[c] : en[c];
            res[c*DATA_W +: DATA_W] = cur_mode ? DATA_W'(merged[c] >>> SH)
                                               : DATA_W'(merged[c]);
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        col_d   = col_q;
        row_d   = row_q;
        pc_d    = pc_q;
        pr_d    = pr_q;
        wc_d    = wc_q;
        wr_d    = wr_q;
        if (accept) begin
            if (state_q == IDLE) begin
                state_d = RUN;
                mode_d  = pool_mode;
            end
            col_d = last_col ? '0 : col_q + 1'b1;
            pc_d  = (last_col || pc_end) ? '0 : pc_q + 1'b1;
            wc_d  = last_col ? '0 : (pc_end ? wc_q + 1'b1 : wc_q);
            if (last_col) begin
                row_d = last_row ? '0 : row_q + 1'b1;
                pr_d  = (last_row || pr_end) ? '0 : pr_q + 1'b1;
                wr_d  = last_row ? '0 : (pr_end ? wr_q + 1'b1 : wr_q);
                if (last_row)
                    state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            pc_q        <= '0;
            pr_q        <= '0;
            wc_q        <= '0;
            wr_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int w = 0; w < OUT_W; w++)
                for (int c = 0; c < CHANNELS; c++)
                    acc_q[w][c] <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pc_q    <= pc_d;
            pr_q    <= pr_d;
            wc_q    <= wc_d;
            wr_q    <= wr_d;
            if (accept && in_win)
                for (int c = 0; c < CHANNELS; c++)
                    acc_q[wi][c] <= merged[c];
            // A completing window always wins over draining the old result.
            if (done) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res;
                out_last_q  <= win_last;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: 4x4 and 5x5 instances, directed and random frames
// checked against a window-by-window pooling model.
module tb_pool2d_stream;

    logic             clock;
    logic             reset_n;
    logic [1:0]       mode, iv, ordy, ir, ov, ol;
    logic [1:0][31:0] id, od;

    int nvec = 0;
    int nerr = 0;

    logic signed [7:0] pix [5][5][4];
    logic [31:0]       expd[$];
    logic              expl[$];

    pool2d_stream #(.DATA_W(8), .CHANNELS(4), .IMAGE_HEIGHT(4),
                    .IMAGE_WIDTH(4), .POOL_H(2), .POOL_W(2)) u0 (
        .clock(clock), .reset_n(reset_n), .pool_mode(mode[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .out_last(ol[0]));

    pool2d_stream #(.DATA_W(8), .CHANNELS(4), .IMAGE_HEIGHT(5),
                    .IMAGE_WIDTH(5), .POOL_H(2), .POOL_W(2)) u1 (
        .clock(clock), .reset_n(reset_n), .pool_mode(mode[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .out_last(ol[1]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        nvec++;
        assert (got === want) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] pk(int r, int c);
        logic [31:0] w;
        for (int ch = 0; ch < 4; ch++) w[ch*8 +: 8] = pix[r][c][ch];
        return w;
    endfunction

    task automatic fill(int s, int kind);
        int n;
        n = s ? 5 : 4;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int ch = 0; ch < 4; ch++) begin
                    int idx;
                    idx = r * n + c;
                    case (kind)
                        0: pix[r][c][ch] = 8'(idx);
                        1: pix[r][c][ch] = 8'(idx * (ch + 1) - 20 * ch);
                        default: pix[r][c][ch] = 8'($urandom);
                    endcase
                end
    endtask

    task automatic build_exp(int s, bit m);
        int n, on;
        n  = s ? 5 : 4;
        on = n / 2;
        expd.delete();
        expl.delete();
        for (int wr = 0; wr < on; wr++)
            for (int wc = 0; wc < on; wc++) begin
                logic [31:0] w;
                for (int ch = 0; ch < 4; ch++) begin
                    int sum, mx, v;
                    sum = 0;
                    mx  = -1000;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++) begin
                            v = pix[2*wr+dr][2*wc+dc][ch];
                            sum += v;
                            if (v > mx) mx = v;
                        end
                    v = m ? (sum >>> 2) : mx;
                    w[ch*8 +: 8] = 8'(v);
                end
                expd.push_back(w);
                expl.push_back(wr == on - 1 && wc == on - 1);
            end
    endtask

    // stall: 0 = always ready, 1 = hold ready low 3 cycles per result, 2 = random
    task automatic run_frame(int s, bit m, int stall);
        int n, np, pi, got, nexp, cyc, sc;
        bit stalled, heldl;
        logic [31:0] held;
        n = s ? 5 : 4;
        np = n * n;
        build_exp(s, m);
        nexp = expd.size();
        pi = 0; got = 0; cyc = 0; sc = 0;
        stalled = 0; held = '0; heldl = 0;
        while ((pi < np || got < nexp) && cyc < 400) begin
            @(negedge clock);
            if (stalled) begin
                chk("hold_data", od[s], held);
                chk("hold_last", 32'(ol[s]), 32'(heldl));
            end
            if (stall == 1) begin
                if (ov[s] && sc < 3) begin
                    ordy[s] = 1'b0;
                    sc++;
                end else ordy[s] = 1'b1;
            end else if (stall == 2) ordy[s] = 1'($urandom_range(1));
            else ordy[s] = 1'b1;
            iv[s] = (pi < np) && (stall != 2 || $urandom_range(3) != 0);
            id[s] = (pi < np) ? pk(pi / n, pi % n) : 32'h0;
            mode[s] = (pi == 0) ? m : ~m;
            #1;
            chk("in_ready", 32'(ir[s]), 32'(!ov[s] || ordy[s]));
            if (ov[s] && ordy[s]) begin
                if (got < nexp) begin
                    chk("out_data", od[s], expd[got]);
                    chk("out_last", 32'(ol[s]), 32'(expl[got]));
                end else chk("extra_out", 32'(ov[s]), 32'h0);
                got++;
                sc = 0;
            end
            stalled = ov[s] && !ordy[s];
            held = od[s];
            heldl = ol[s];
            if (iv[s] && ir[s]) pi++;
            cyc++;
        end
        @(negedge clock);
        iv[s] = 1'b0;
        ordy[s] = 1'b1;
        chk("pixels_taken", 32'(pi), 32'(np));
        chk("results_seen", 32'(got), 32'(nexp));
        repeat (2) @(negedge clock);
        chk("idle_valid", 32'(ov[s]), 32'h0);
    endtask

    task automatic chk_reset(int s);
        chk("rst_in_ready", 32'(ir[s]), 32'h1);
        chk("rst_out_valid", 32'(ov[s]), 32'h0);
        chk("rst_out_last", 32'(ol[s]), 32'h0);
        chk("rst_out_data", od[s], 32'h0);
    endtask

    initial begin
        int pi, cyc;
        reset_n = 1'b0;
        mode = '0; iv = '0; ordy = '1; id = '0;
        #12;
        chk_reset(0);
        chk_reset(1);
        @(negedge clock);
        reset_n = 1'b1;

        fill(0, 0);
        run_frame(0, 1'b0, 0);
        run_frame(0, 1'b1, 0);

        fill(0, 0);
        pix[0][0][0] = -8; pix[0][1][0] = -3;
        pix[1][0][0] = -5; pix[1][1][0] = -1;
        run_frame(0, 1'b0, 0);
        run_frame(0, 1'b1, 0);

        fill(0, 1);
        run_frame(0, 1'b0, 1);
        run_frame(0, 1'b1, 1);

        fill(1, 0);
        run_frame(1, 1'b0, 0);
        run_frame(1, 1'b1, 1);

        fill(0, 0);
        pi = 0;
        cyc = 0;
        while (pi < 7 && cyc < 50) begin
            @(negedge clock);
            iv[0] = 1'b1;
            id[0] = pk(pi / 4, pi % 4);
            mode[0] = (pi == 0) ? 1'b1 : 1'b0;
            #1;
            if (ir[0]) pi++;
            cyc++;
        end
        chk("partial_pixels", 32'(pi), 32'd7);
        @(negedge clock);
        iv[0] = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset(0);
        @(negedge clock);
        reset_n = 1'b1;
        run_frame(0, 1'b0, 0);

        for (int k = 0; k < 16; k++) begin
            int s;
            s = k % 2;
            fill(s, 2);
            run_frame(s, 1'($urandom_range(1)), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
